seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 162 ++++++++++++++++
 tb/tb_seq_divider.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, done pulse on completion.
// Optional two's-complement mode is enabled by defining DIV_SIGNED_EN (adds one fix-up cycle).
module seq_divider #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             dbz
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] CNT_TOP = CW'(width - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] dvs_q, dvs_d;
  logic [width-1:0] quo_q, quo_d;
  logic [width:0]   prem_q, prem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [width-1:0] quotient_q, quotient_d;
  logic [width-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [width+1:0] shifted, trial;
  logic             take;
  logic [width:0]   prem_nx;
  logic [width-1:0] quo_nx;
  logic [width-1:0] mag1, mag2;

`ifdef DIV_SIGNED_EN
  localparam logic [width-1:0] ONE = width'(1);
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  assign mag1 = in1[width-1] ? (~in1 + ONE) : in1;
  assign mag2 = in2[width-1] ? (~in2 + ONE) : in2;
`else
  assign mag1 = in1;
  assign mag2 = in2;
`endif

  // One restoring step: shift {prem, quo} left, keep the trial difference if it did not borrow.
  assign shifted = {prem_q, quo_q[width-1]};
  assign trial   = shifted - {2'b00, dvs_q};
  assign take    = ~trial[width+1];
  assign prem_nx = take ? trial[width:0] : shifted[width:0];
  assign quo_nx  = {quo_q[width-2:0], take};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    prem_d      = prem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    negq_d      = negq_q;
    negr_d      = negr_q;
`endif
    case (state_q)
      S_CALC: begin
        prem_d = prem_nx;
        quo_d  = quo_nx;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
          state_d = S_SIGN;
`else
          state_d     = S_DONE;
          quotient_d  = quo_nx;
          remainder_d = prem_nx[width-1:0];
          dbz_d       = 1'b0;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      S_SIGN: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        state_d     = S_DONE;
        quotient_d  = negq_q ? (~quo_q + ONE) : quo_q;
        remainder_d = negr_q ? (~prem_q[width-1:0] + ONE) : prem_q[width-1:0];
        dbz_d       = 1'b0;
      end
`endif
      default: begin
        state_d = S_IDLE;
        if (start) begin
          if (in2 == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = in1;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_CALC;
            cnt_d   = CNT_TOP;
            dvs_d   = mag2;
            quo_d   = mag1;
            prem_d  = '0;
`ifdef DIV_SIGNED_EN
            negq_d  = in1[width-1] ^ in2[width-1];
            negr_d  = in1[width-1];
`endif
          end
        end
      end
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_SIGN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      prem_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      prem_q      <= prem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      negq_q      <= negq_d;
      negr_q      <= negr_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model with a per-cycle compare, directed cases, random pairs.
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic       clk, rst, start;
  logic [7:0] in1, in2;
  logic       busy, done, dbz;
  logic [7:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  seq_divider #(.width(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic d);
    d = 1'b0;
    if (b == 8'd0) begin
      q = 8'hFF; r = a; d = 1'b1;
    end
`ifdef DIV_SIGNED_EN
    else begin
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin q = 8'h80; r = 8'h00; end
      else begin q = 8'(sa / sb); r = 8'(sa % sb); end
    end
`else
    else begin
      q = a / b; r = a % b;
    end
`endif
  endtask

  // Reference: a countdown to completion plus the arithmetic result it will deliver.
  int         m_left = 0;
  bit         m_done = 0;
  logic [7:0] m_q = 0, m_r = 0, p_q, p_r;
  logic       m_dbz = 0, p_dbz;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 0; m_q = 0; m_r = 0; m_dbz = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_done = 1; m_q = p_q; m_r = p_r; m_dbz = p_dbz; end
      end else if (start) begin
        ref_div(in1, in2, p_q, p_r, p_dbz);
        if (in2 == 8'd0) begin m_done = 1; m_q = p_q; m_r = p_r; m_dbz = p_dbz; end
        else m_left = LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("cyc_done", {31'd0, done}, {31'd0, m_done});
      chk("cyc_quotient", {24'd0, quotient}, {24'd0, m_q});
      chk("cyc_remainder", {24'd0, remainder}, {24'd0, m_r});
      chk("cyc_dbz", {31'd0, dbz}, {31'd0, m_dbz});
    end
  end

  task automatic pulse(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin lat = i; break; end
      if (busy) bcnt++;
      @(negedge clk);
    end
    chk("done_seen", {31'd0, lat >= 0}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input logic ed);
    int lat, bc;
    pulse(a, b);
    wait_done(lat, bc);
    chk({tag, "_q"}, {24'd0, quotient}, {24'd0, eq});
    chk({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
    chk({tag, "_dbz"}, {31'd0, dbz}, {31'd0, ed});
    chk({tag, "_lat"}, lat, ed ? 0 : LAT);
    chk({tag, "_busycyc"}, bc, ed ? 0 : LAT);
  endtask

  logic [7:0] ra, rb;
  int         lat, bc, dc, inv;
  bit         b2b, inj;

  initial begin
    rst = 1'b1; start = 1'b0; in1 = 8'd0; in2 = 8'd0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef DIV_SIGNED_EN
    run("s_m100_7", 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0);
    run("s_ovf", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    run("s_dbz", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
    run("s_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
`else
    run("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    run("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run("d3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0);
    run("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    run("dbz5", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
    run("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
    // Second start lands mid-CALC and must be dropped.
    pulse(8'd100, 8'd9);
    repeat (2) @(negedge clk);
    pulse(8'd50, 8'd5);
    wait_done(lat, bc);
    chk("ign_q", {24'd0, quotient}, 32'd11);
    chk("ign_r", {24'd0, remainder}, 32'd1);
    // Start issued in the done cycle is accepted.
    run("b2b_50_5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
    // Reset in CALC cycle 4 aborts without a done pulse.
    pulse(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_q", {24'd0, quotient}, 32'd0);
    chk("abort_r", {24'd0, remainder}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    dc = 0;
    repeat (12) begin if (done) dc++; @(negedge clk); end
    chk("abort_nodone", dc, 0);
    run("post_rst", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
`endif

    b2b = 0;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse(ra, rb);
      inj = (rb != 8'd0) && ($urandom_range(0, 3) == 0);
      if (inj) begin
        @(negedge clk);
        pulse(8'($urandom), 8'($urandom));
      end
      wait_done(lat, bc);
      chk("rnd_lat", lat, (rb == 8'd0) ? 0 : (inj ? LAT - 2 : LAT));
`ifndef DIV_SIGNED_EN
      if (rb != 8'd0) begin
        inv = int'(quotient) * int'(rb) + int'(remainder);
        chk("rnd_invariant", inv, int'(ra));
        chk("rnd_rem_lt_div", {31'd0, remainder < rb}, 32'd1);
      end
`endif
      b2b = 1'($urandom_range(0, 1));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
